// File: rtl/wl_fetch_driver.sv
// rtl/wl_fetch_driver.sv - instruction-fetch transmitter driving store words onto the write lines
// Walks Z through a loadable fixed-memory image, one word per MCT, strobing nisq for SQ.
module wl_fetch_driver #(
  parameter logic [11:0] ORIGIN = 12'o4000,
  parameter int          AW     = 6
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          gojam,
  input  logic          stop,
  input  logic          t01,
  input  logic          t12,
  input  logic          wt_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data,
  output logic [15:0]   wl,
  output logic [15:0]   wl_n,
  output logic          nisq,
  output logic [11:0]   z,
  output logic          par_alm
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, HALT} state_t;

  state_t        state;
  logic [15:0]   mem [2**AW];
  logic [15:0]   g;
  logic          t01_q;
  logic          t12_q;
  logic          adv;
  logic          t01_re;
  logic          t12_fe;
  logic [AW-1:0] index;

  assign t01_re = t01 & ~t01_q;
  assign t12_fe = t12_q & ~t12;
  // Z outside the image aliases back into it through the truncated offset.
  assign index  = AW'(z - ORIGIN);

  // No reset: the image survives gojam and is undefined at power-up.
  always_ff @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      z       <= ORIGIN;
      nisq    <= 1'b0;
      g       <= 16'h0000;
      par_alm <= 1'b0;
      adv     <= 1'b0;
      t01_q   <= 1'b0;
      t12_q   <= 1'b0;
    end else begin
      t01_q <= t01;
      t12_q <= t12;
      if (gojam) begin
        state   <= IDLE;
        z       <= ORIGIN;
        nisq    <= 1'b0;
        g       <= 16'h0000;
        par_alm <= 1'b0;
        adv     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (t01_re && !stop) state <= READ;
          end
          READ: begin
            g    <= mem[index];
            if (~^mem[index]) par_alm <= 1'b1;
            nisq  <= 1'b1;
            state <= WAIT;
          end
          WAIT: begin
            if (t12_fe) begin
              z    <= z + 12'd1;
              nisq <= 1'b0;
            end
            // t12 falling and t01 rising normally land on the same edge; treat that as back-to-back.
            if (t01_re && (adv || t12_fe)) begin
              adv   <= 1'b0;
              state <= stop ? HALT : READ;
            end else if (t12_fe) begin
              adv <= 1'b1;
            end
          end
          HALT: begin
            nisq <= 1'b0;
            if (t01_re && !stop) state <= READ;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign wl   = g & {16{t12 & ~wt_n & (state == WAIT)}};
  assign wl_n = ~wl;

endmodule
